// File: rtl/param_lock_if.sv
// Keypad-to-lock signal bundle for param_lock_top; prog_en/prog_code exist only
// when PARAM_LOCK_PROG_EN is defined.
`timescale 1ns/1ps
interface param_lock_if #(
  parameter int unsigned NUM_BTNS = 2,
  parameter int unsigned CODE_LEN = 4,
  parameter int unsigned MAX_FAIL = 3
);
  localparam int unsigned CW = $clog2(CODE_LEN + 1);
  localparam int unsigned FW = $clog2(MAX_FAIL + 1);

  logic [NUM_BTNS-1:0] btn;
  logic                unlock;
  logic                locked_out;
  logic [CW-1:0]       digit_cnt;
  logic [FW-1:0]       fail_cnt;

`ifdef PARAM_LOCK_PROG_EN
  localparam int unsigned DW = $clog2(NUM_BTNS);
  logic                   prog_en;
  logic [DW*CODE_LEN-1:0] prog_code;

  modport master (output btn, prog_en, prog_code,
                  input  unlock, locked_out, digit_cnt, fail_cnt);
  modport slave  (input  btn, prog_en, prog_code,
                  output unlock, locked_out, digit_cnt, fail_cnt);
`else
  modport master (output btn,
                  input  unlock, locked_out, digit_cnt, fail_cnt);
  modport slave  (input  btn,
                  output unlock, locked_out, digit_cnt, fail_cnt);
`endif
endinterface

// File: rtl/param_lock_top.sv
// Parametrised N-button code lock with edge detection, failed-attempt lockout and
// timed auto-relock. Optional runtime code programming under PARAM_LOCK_PROG_EN.
`timescale 1ns/1ps
module param_lock_top #(
  parameter int unsigned NUM_BTNS       = 2,
  parameter int unsigned CODE_LEN       = 4,
  parameter logic [$clog2(NUM_BTNS)*CODE_LEN-1:0] CODE = 'b1011,
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 5000
) (
  input  logic clk,
  input  logic btn_reset_n,
  param_lock_if.slave bus
);
  localparam int unsigned DW   = $clog2(NUM_BTNS);
  localparam int unsigned KW   = DW * CODE_LEN;
  localparam int unsigned CW   = $clog2(CODE_LEN + 1);
  localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [1:0] {IDLE, UNLOCKED, LOCKOUT} state_t;

  state_t              state;
  logic [NUM_BTNS-1:0] btn_q;
  logic [CW-1:0]       digit_cnt;
  logic [FW-1:0]       fail_cnt;
  logic [TW-1:0]       timer;
  logic                mismatch;
  logic                unlock_q;
  logic                locked_q;
  logic [KW-1:0]       code_q;
  logic                prog_hit;

  logic [NUM_BTNS-1:0] press;
  logic                any_press;
  logic                one_press;
  logic [DW-1:0]       press_idx;
  logic [DW-1:0]       code_digit;
  logic                mismatch_nxt;
  logic                last_digit;
  logic [FW-1:0]       fail_inc;

`ifdef PARAM_LOCK_PROG_EN
  // Programmable code: reloaded from CODE on reset, rewritten only while unlocked.
  always_ff @(posedge clk or negedge btn_reset_n) begin
    if (!btn_reset_n) begin
      code_q <= CODE;
    end else if (state == UNLOCKED && bus.prog_en) begin
      code_q <= bus.prog_code;
    end
  end
  assign prog_hit = (state == UNLOCKED) && bus.prog_en;
`else
  assign code_q   = CODE;
  assign prog_hit = 1'b0;
`endif

  assign press     = bus.btn & ~btn_q;
  assign any_press = |press;
  assign one_press = $onehot(press);

  // Index of the pressed button; only meaningful when exactly one bit is set.
  always_comb begin
    press_idx = '0;
    for (int k = 0; k < NUM_BTNS; k++) begin
      if (press[k]) press_idx = DW'(k);
    end
  end

  always_comb begin
    code_digit = '0;
    for (int i = 0; i < CODE_LEN; i++) begin
      if (digit_cnt == CW'(i)) code_digit = code_q[i*DW +: DW];
    end
  end

  // Multi-button presses count as one wrong digit.
  assign mismatch_nxt = mismatch | ~one_press | (press_idx != code_digit);
  assign last_digit   = (digit_cnt == CW'(CODE_LEN - 1));
  assign fail_inc     = (fail_cnt == FW'(MAX_FAIL)) ? fail_cnt : fail_cnt + FW'(1);

  always_ff @(posedge clk or negedge btn_reset_n) begin
    if (!btn_reset_n) begin
      state     <= IDLE;
      btn_q     <= '1;
      digit_cnt <= '0;
      fail_cnt  <= '0;
      timer     <= '0;
      mismatch  <= 1'b0;
      unlock_q  <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      btn_q <= bus.btn;
      unique case (state)
        IDLE: begin
          if (any_press) begin
            if (last_digit) begin
              digit_cnt <= '0;
              mismatch  <= 1'b0;
              timer     <= '0;
              if (!mismatch_nxt) begin
                state    <= UNLOCKED;
                unlock_q <= 1'b1;
                fail_cnt <= '0;
              end else begin
                fail_cnt <= fail_inc;
                if (fail_inc == FW'(MAX_FAIL)) begin
                  state    <= LOCKOUT;
                  locked_q <= 1'b1;
                end
              end
            end else begin
              digit_cnt <= digit_cnt + CW'(1);
              mismatch  <= mismatch_nxt;
            end
          end
        end
        // Any press (consumed), a code write, or timeout relocks.
        UNLOCKED: begin
          if (any_press || prog_hit || timer == TW'(UNLOCK_CYCLES - 1)) begin
            state    <= IDLE;
            unlock_q <= 1'b0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        LOCKOUT: begin
          if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
            state    <= IDLE;
            locked_q <= 1'b0;
            fail_cnt <= '0;
            timer    <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          unlock_q <= 1'b0;
          locked_q <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

  assign bus.unlock     = unlock_q;
  assign bus.locked_out = locked_q;
  assign bus.digit_cnt  = digit_cnt;
  assign bus.fail_cnt   = fail_cnt;
endmodule

// File: tb/tb_param_lock_top.sv
// Scoreboard bench for param_lock_top: expectations are queued as buttons are
// driven and compared one clock edge later.
`timescale 1ns/1ps
module tb_param_lock_top;
  logic clk = 1'b0;
  logic btn_reset_n;

  always #5 clk = ~clk;

  param_lock_if #(.NUM_BTNS(2), .CODE_LEN(4), .MAX_FAIL(3)) bus();

  param_lock_top #(
    .NUM_BTNS(2), .CODE_LEN(4), .CODE(4'b1011), .MAX_FAIL(3),
    .LOCKOUT_CYCLES(1000), .UNLOCK_CYCLES(5000)
  ) dut (
    .clk(clk),
    .btn_reset_n(btn_reset_n),
    .bus(bus)
  );

  typedef struct {
    string tag;
    logic  u;
    logic  lo;
    int    dc;
    int    fc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, want);
    end
  endtask

  task automatic check_outputs(input string tag, input logic u, input logic lo,
                               input int dc, input int fc);
    check({tag, ".unlock"},     32'(bus.unlock),     32'(u));
    check({tag, ".locked_out"}, 32'(bus.locked_out), 32'(lo));
    check({tag, ".digit_cnt"},  32'(bus.digit_cnt),  dc);
    check({tag, ".fail_cnt"},   32'(bus.fail_cnt),   fc);
  endtask

  // Compare the queued expectation against the state after each active edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check_outputs(cur.tag, cur.u, cur.lo, cur.dc, cur.fc);
    end
  end

  task automatic expect_next(input string tag, input logic u, input logic lo,
                             input int dc, input int fc);
    exp_t e;
    e.tag = tag; e.u = u; e.lo = lo; e.dc = dc; e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [1:0] b, input string tag, input logic u,
                      input logic lo, input int dc, input int fc);
    @(negedge clk);
    bus.btn = b;
    expect_next(tag, u, lo, dc, fc);
  endtask

  task automatic press(input logic [1:0] b, input string tag, input logic u,
                       input logic lo, input int dc, input int fc);
    step(b, tag, u, lo, dc, fc);
    step(2'b00, {tag, "_rel"}, u, lo, dc, fc);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.btn = 2'b00;
`ifdef PARAM_LOCK_PROG_EN
    bus.prog_en   = 1'b0;
    bus.prog_code = '0;
`endif
    btn_reset_n = 1'b0;
    #12;
    check_outputs("reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    btn_reset_n = 1'b1;

    // Correct code 1,1,0,1 then auto-relock after 5000 cycles.
    press(2'b10, "ok_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "ok_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "ok_d2", 1'b0, 1'b0, 3, 0);
    step(2'b10, "ok_unlock", 1'b1, 1'b0, 0, 0);
    step(2'b00, "ok_hold",   1'b1, 1'b0, 0, 0);
    idle(4997);
    step(2'b00, "ok_last_cycle", 1'b1, 1'b0, 0, 0);
    step(2'b00, "ok_autorelock", 1'b0, 1'b0, 0, 0);

    // Three wrong attempts lead to lockout.
    for (int a = 1; a <= 3; a++) begin
      press(2'b01, $sformatf("bad%0d_d0", a), 1'b0, 1'b0, 1, a - 1);
      press(2'b01, $sformatf("bad%0d_d1", a), 1'b0, 1'b0, 2, a - 1);
      press(2'b01, $sformatf("bad%0d_d2", a), 1'b0, 1'b0, 3, a - 1);
      if (a < 3) press(2'b01, $sformatf("bad%0d_d3", a), 1'b0, 1'b0, 0, a);
    end
    step(2'b01, "lock_enter", 1'b0, 1'b1, 0, 3);
    step(2'b00, "lock_hold",  1'b0, 1'b1, 0, 3);
    press(2'b10, "lock_ignored", 1'b0, 1'b1, 0, 3);
    idle(995);
    step(2'b00, "lock_last_cycle", 1'b0, 1'b1, 0, 3);
    step(2'b00, "lock_exit",       1'b0, 1'b0, 0, 0);

    // Simultaneous press is one wrong digit; then a good code clears fail_cnt.
    press(2'b11, "both_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "both_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "both_d2", 1'b0, 1'b0, 3, 0);
    press(2'b10, "both_fail", 1'b0, 1'b0, 0, 1);
    press(2'b10, "clr_d0", 1'b0, 1'b0, 1, 1);
    press(2'b10, "clr_d1", 1'b0, 1'b0, 2, 1);
    press(2'b01, "clr_d2", 1'b0, 1'b0, 3, 1);
    press(2'b10, "clr_unlock", 1'b1, 1'b0, 0, 0);
    press(2'b01, "clr_press_relock", 1'b0, 1'b0, 0, 0);

    // Buttons held through reset release produce no press.
    @(negedge clk);
    bus.btn = 2'b11;
    btn_reset_n = 1'b0;
    #2;
    check_outputs("held_in_reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    btn_reset_n = 1'b1;
    step(2'b11, "held_no_press", 1'b0, 1'b0, 0, 0);
    step(2'b00, "held_release",  1'b0, 1'b0, 0, 0);
    press(2'b10, "held_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "held_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "held_d2", 1'b0, 1'b0, 3, 0);
    press(2'b10, "held_unlock", 1'b1, 1'b0, 0, 0);
    press(2'b10, "held_relock", 1'b0, 1'b0, 0, 0);

    // Asynchronous reset in the middle of an attempt.
    press(2'b10, "ar_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "ar_d1", 1'b0, 1'b0, 2, 0);
    @(negedge clk);
    #2;
    btn_reset_n = 1'b0;
    #1;
    check_outputs("async_reset", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    btn_reset_n = 1'b1;
    press(2'b10, "ar2_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "ar2_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "ar2_d2", 1'b0, 1'b0, 3, 0);
    press(2'b10, "ar2_unlock", 1'b1, 1'b0, 0, 0);
    press(2'b01, "ar2_relock", 1'b0, 1'b0, 0, 0);

`ifdef PARAM_LOCK_PROG_EN
    // Reprogram to 0,0,0,0 while unlocked; the old code must then fail.
    press(2'b10, "pg_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "pg_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "pg_d2", 1'b0, 1'b0, 3, 0);
    press(2'b10, "pg_unlock", 1'b1, 1'b0, 0, 0);
    @(negedge clk);
    bus.prog_code = 4'b0000;
    bus.prog_en   = 1'b1;
    expect_next("pg_load_relock", 1'b0, 1'b0, 0, 0);
    @(negedge clk);
    bus.prog_en   = 1'b0;
    press(2'b01, "pg_new_d0", 1'b0, 1'b0, 1, 0);
    press(2'b01, "pg_new_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "pg_new_d2", 1'b0, 1'b0, 3, 0);
    press(2'b01, "pg_new_unlock", 1'b1, 1'b0, 0, 0);
    press(2'b10, "pg_new_relock", 1'b0, 1'b0, 0, 0);
    press(2'b10, "pg_old_d0", 1'b0, 1'b0, 1, 0);
    press(2'b10, "pg_old_d1", 1'b0, 1'b0, 2, 0);
    press(2'b01, "pg_old_d2", 1'b0, 1'b0, 3, 0);
    press(2'b10, "pg_old_fail", 1'b0, 1'b0, 0, 1);
`endif

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/param_lock_top.md
Name: param_lock_top

Overview:
Next-generation button code lock: N-button keypad, parametrised code length, per-button rising-edge detection built in, failed-attempt counting with timed lockout, and timed auto-relock. It is the top-level lock block and connects directly to raw, already-debounced button levels. It replaces the fixed two-button lock with a single parametrised block.

Parameters:
NUM_BTNS, 2, number of keypad buttons; legal range 2..16.
DW, $clog2(NUM_BTNS), digit width (localparam; not overridden).
CODE_LEN, 4, digits per attempt; legal range 1..16.
CODE, 'b1011 (DW*CODE_LEN bits), unlock code; digit i = CODE[i*DW +: DW]; digit 0 is entered first.
MAX_FAIL, 3, consecutive failed attempts that trigger lockout; legal range >=1.
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles; legal range >=1.
UNLOCK_CYCLES, 5000, unlocked duration before auto-relock; legal range >=1.

Ports:
clk  in  1  system clock, rising edge.
btn_reset_n  in  1  asynchronous, active-low reset.
btn  in  NUM_BTNS  button levels, synchronous to clk; bit k is button k.
unlock  out  1  high while in UNLOCKED.
locked_out  out  1  high while in LOCKOUT.
digit_cnt  out  $clog2(CODE_LEN+1)  digits entered in the current attempt.
fail_cnt  out  $clog2(MAX_FAIL+1)  consecutive failed attempts.

Behaviour:
- Reset (btn_reset_n low, asynchronous): state IDLE; unlock=0, locked_out=0, digit_cnt=0, fail_cnt=0; mismatch flag=0; timer=0; btn_q (previous levels) = all ones. Buttons held through reset therefore produce no press.
- Edge detect: press event on edge E when btn[k]=1 at E and btn_q[k]=0; btn_q <= btn on every edge in every state.
- Press classification: exactly one bit set means a valid digit, its index. More than one bit set means a single wrong digit (mismatch forced).
- IDLE/ENTRY: on each press, compare the digit with CODE digit[digit_cnt] and OR any inequality into mismatch. If digit_cnt < CODE_LEN-1, digit_cnt++.
- On the CODE_LEN-th press:
  - mismatch clear: go to UNLOCKED. unlock=1 from edge E+ (zero added latency). fail_cnt=0.
  - mismatch set: fail_cnt++. If the new fail_cnt equals MAX_FAIL, go to LOCKOUT.
  - In both cases digit_cnt=0 and mismatch=0.
- Full code is always entered before judging; early mismatch does not abort the attempt.
- UNLOCKED: timer counts 0..UNLOCK_CYCLES-1, then returns to IDLE, unlock=0. Any press in UNLOCKED relocks immediately to IDLE. That press is consumed and does not count as a digit.
- LOCKOUT: presses ignored. After LOCKOUT_CYCLES cycles go to IDLE, locked_out=0, fail_cnt=0.
- Timer is cleared on every state entry. States are mutually exclusive, so unlock and locked_out are never both high.
- Reset mid-attempt, mid-unlock or mid-lockout: immediate return to reset values.
- fail_cnt saturates at MAX_FAIL and never wraps.

Optional Feature:
Macro PARAM_LOCK_PROG_EN.
- Defined:
  - Extra ports: prog_en (in, 1) and prog_code (in, DW*CODE_LEN).
  - The code is held in a register loaded from CODE at reset.
  - While unlock=1, prog_en high for one cycle loads prog_code into the register on that edge and relocks to IDLE.
  - prog_en is ignored in every other state.
- Undefined: no extra ports; the code is the constant CODE.

Test Plan:
- NUM_BTNS=2, CODE_LEN=4, CODE=1011b, press sequence 1,1,0,1 -> unlock=1 on the fourth press edge, fail_cnt=0; after 5000 cycles unlock=0.
- Sequence 0,0,0,0 three times -> fail_cnt counts 1, 2, then locked_out=1. Further presses leave digit_cnt=0. After 1000 cycles locked_out=0 and fail_cnt=0.
- Both buttons rise on the same edge, followed by three correct digits -> counted as a failed attempt, fail_cnt=1, unlock=0.
- btn=11b held while btn_reset_n is deasserted -> no press registered and digit_cnt=0. A release then a valid press -> digit_cnt=1.
- Two correct digits, pulse btn_reset_n low asynchronously -> digit_cnt=0 and state IDLE immediately. A full correct code then unlocks.
- PARAM_LOCK_PROG_EN defined: unlock, pulse prog_en with prog_code=0000b -> relock. Entering 0,0,0,0 -> unlock=1. The old code 1,1,0,1 -> fail.
